mesh_hs_monitor: RTL and testbench



---
 rtl/mesh_hs_monitor_pkg.sv | 21 ++
 rtl/mesh_hs_monitor_if.sv | 12 +
 rtl/mesh_hs_monitor_chan.sv | 128 ++++++++++++
 rtl/mesh_hs_monitor.sv | 100 ++++++++++
 tb/tb_mesh_hs_monitor.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mesh_hs_monitor_pkg.sv
// Shared types and helpers for the mesh terminal handshake monitor.
package mesh_mon_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, LATE} hs_state_t;

  // Width needed to hold latencies 0..max_wait.
  function automatic int unsigned lat_w(input int unsigned max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

  // Router output side (pndng -> pop) occupies channels 0..CHANNELS-1.
  function automatic int unsigned out_chan(input int unsigned term);
    return term;
  endfunction

  // Router input side (pndng_i_in -> popin) occupies channels CHANNELS..2*CHANNELS-1.
  function automatic int unsigned in_chan(input int unsigned term, input int unsigned channels);
    return channels + term;
  endfunction

endpackage

// File: rtl/mesh_hs_monitor_if.sv
// Terminal-side handshake signals of the mesh router, as seen by the monitor.
interface mesh_hs_monitor_if #(
  parameter int unsigned CHANNELS = 16
);
  logic [CHANNELS-1:0] pndng;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] pndng_i_in;
  logic [CHANNELS-1:0] popin;

  modport master (output pndng, pop, pndng_i_in, popin);
  modport slave  (input  pndng, pop, pndng_i_in, popin);
endinterface

// File: rtl/mesh_hs_monitor_chan.sv
// One req/ack channel checker: rise-to-rise latency window, saturating
// pass/fail/late counters, worst passing latency and a sticky timeout flag.
module hs_chan_mon
  import mesh_mon_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 50,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned LAT_W   = lat_w(MAX_WAIT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             req,
  input  logic             ack,
  output logic             fail_flag,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] late_cnt,
  output logic [LAT_W-1:0] max_lat
);

  hs_state_t        state, state_n;
  logic [LAT_W-1:0] lat, lat_n, lat_inc, ev_lat;
  logic             req_q, ack_q;
  logic             req_rise, ack_rise;
  logic             pass_ev, fail_ev, late_ev;

  assign req_rise = req & ~req_q;
  assign ack_rise = ack & ~ack_q;
  assign lat_inc  = lat + LAT_W'(1);

  // Edge history keeps sampling regardless of en/clr so re-enabling never fakes a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      req_q <= req;
      ack_q <= ack;
    end
  end

  // FSM state and latency register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lat   <= '0;
    end else if (clr) begin
      state <= IDLE;
      lat   <= '0;
    end else begin
      state <= state_n;
      lat   <= lat_n;
    end
  end

  // Next state and per-edge pass/fail/late events.
  always_comb begin
    state_n = state;
    lat_n   = lat;
    ev_lat  = '0;
    pass_ev = 1'b0;
    fail_ev = 1'b0;
    late_ev = 1'b0;
    if (!en) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, LATE: begin
          // In LATE an ack rise closes the timed-out attempt before any new req is considered.
          if (state == LATE && ack_rise) begin
            late_ev = 1'b1;
            state_n = IDLE;
          end else if (req_rise) begin
            if (ack_rise) begin
              pass_ev = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = WAIT;
              lat_n   = '0;
            end
          end
        end
        WAIT: begin
          lat_n = lat_inc;
          if (ack_rise) begin
            pass_ev = 1'b1;
            ev_lat  = lat_inc;
            state_n = IDLE;
          end else if (lat_inc == LAT_W'(MAX_WAIT)) begin
            fail_ev = 1'b1;
            state_n = LATE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Saturating counters, worst latency and sticky fail flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      late_cnt  <= '0;
      max_lat   <= '0;
      fail_flag <= 1'b0;
    end else if (clr) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      late_cnt  <= '0;
      max_lat   <= '0;
      fail_flag <= 1'b0;
    end else begin
      if (pass_ev) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        if (ev_lat > max_lat) max_lat <= ev_lat;
      end
      if (fail_ev) begin
        fail_flag <= 1'b1;
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
      end
      if (late_ev && late_cnt != '1) late_cnt <= late_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mesh_hs_monitor.sv
// Mesh terminal handshake monitor: one checker per direction per terminal,
// a fail summary and a registered per-channel readout port.
module mesh_hs_monitor
  import mesh_mon_pkg::*;
#(
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned MAX_WAIT = 50,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned LAT_W   = lat_w(MAX_WAIT),
  localparam int unsigned SEL_W   = $clog2(2 * CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  mesh_hs_monitor_if.slave      hs,
  input  logic                  rd_req,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [2*CHANNELS-1:0] fail_flag,
  output logic                  any_fail,
  output logic                  rd_valid,
  output logic [CNT_W-1:0]      rd_pass,
  output logic [CNT_W-1:0]      rd_fail,
  output logic [CNT_W-1:0]      rd_late,
  output logic [LAT_W-1:0]      rd_max_lat
);

  localparam int unsigned NCH = 2 * CHANNELS;

  logic [CNT_W-1:0] pass_arr [NCH];
  logic [CNT_W-1:0] fail_arr [NCH];
  logic [CNT_W-1:0] late_arr [NCH];
  logic [LAT_W-1:0] lat_arr  [NCH];
  logic             sel_ok;

  for (genvar t = 0; t < CHANNELS; t++) begin : g_term
    localparam int unsigned OC = out_chan(t);
    localparam int unsigned IC = in_chan(t, CHANNELS);

    hs_chan_mon #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_out (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .clr       (clr),
      .req       (hs.pndng[t]),
      .ack       (hs.pop[t]),
      .fail_flag (fail_flag[OC]),
      .pass_cnt  (pass_arr[OC]),
      .fail_cnt  (fail_arr[OC]),
      .late_cnt  (late_arr[OC]),
      .max_lat   (lat_arr[OC])
    );

    hs_chan_mon #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_in (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .clr       (clr),
      .req       (hs.pndng_i_in[t]),
      .ack       (hs.popin[t]),
      .fail_flag (fail_flag[IC]),
      .pass_cnt  (pass_arr[IC]),
      .fail_cnt  (fail_arr[IC]),
      .late_cnt  (late_arr[IC]),
      .max_lat   (lat_arr[IC])
    );
  end

  assign any_fail = |fail_flag;

  // Extra top bit so the range check also works when 2*CHANNELS is a power of two.
  assign sel_ok = {1'b0, rd_sel} < (SEL_W + 1)'(NCH);

  // Readout: one-cycle registered mux, outputs hold between requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      rd_pass    <= '0;
      rd_fail    <= '0;
      rd_late    <= '0;
      rd_max_lat <= '0;
    end else if (rd_req) begin
      rd_valid <= 1'b1;
      if (sel_ok) begin
        rd_pass    <= pass_arr[rd_sel];
        rd_fail    <= fail_arr[rd_sel];
        rd_late    <= late_arr[rd_sel];
        rd_max_lat <= lat_arr[rd_sel];
      end else begin
        rd_pass    <= '0;
        rd_fail    <= '0;
        rd_late    <= '0;
        rd_max_lat <= '0;
      end
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mesh_hs_monitor.sv
// Directed bench for mesh_hs_monitor: a default instance and a narrow-counter,
// 20-terminal instance for saturation and out-of-range readout.
module tb_mesh_hs_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        rd_req_m = 1'b0;
  logic        rd_req_s = 1'b0;
  logic [4:0]  rd_sel_m = '0;
  logic [5:0]  rd_sel_s = '0;

  logic [31:0] ff_m;
  logic        any_m, vld_m;
  logic [15:0] pass_m, fail_m, late_m;
  logic [5:0]  lat_m;

  logic [39:0] ff_s;
  logic        any_s, vld_s;
  logic [1:0]  pass_s, fail_s, late_s;
  logic [5:0]  lat_s;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  mesh_hs_monitor_if #(.CHANNELS(16)) hs_m ();
  mesh_hs_monitor_if #(.CHANNELS(20)) hs_s ();

  always #5 clk = ~clk;

  mesh_hs_monitor #(.CHANNELS(16), .MAX_WAIT(50), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .hs(hs_m),
    .rd_req(rd_req_m), .rd_sel(rd_sel_m),
    .fail_flag(ff_m), .any_fail(any_m), .rd_valid(vld_m),
    .rd_pass(pass_m), .rd_fail(fail_m), .rd_late(late_m), .rd_max_lat(lat_m)
  );

  mesh_hs_monitor #(.CHANNELS(20), .MAX_WAIT(50), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .hs(hs_s),
    .rd_req(rd_req_s), .rd_sel(rd_sel_s),
    .fail_flag(ff_s), .any_fail(any_s), .rd_valid(vld_s),
    .rd_pass(pass_s), .rd_fail(fail_s), .rd_late(late_s), .rd_max_lat(lat_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 = main output side, 1 = main input side, 2 = small output side
  task automatic set_req(input int unsigned which, input int unsigned ch, input logic v);
    case (which)
      0:       hs_m.pndng[ch] = v;
      1:       hs_m.pndng_i_in[ch] = v;
      default: hs_s.pndng[ch] = v;
    endcase
  endtask

  task automatic set_ack(input int unsigned which, input int unsigned ch, input logic v);
    case (which)
      0:       hs_m.pop[ch] = v;
      1:       hs_m.popin[ch] = v;
      default: hs_s.pop[ch] = v;
    endcase
  endtask

  // req rises at edge t, ack rises at edge t+k, both dropped afterwards.
  task automatic hs(input int unsigned which, input int unsigned ch, input int unsigned k);
    set_req(which, ch, 1'b1);
    tick(k);
    set_ack(which, ch, 1'b1);
    tick(1);
    set_req(which, ch, 1'b0);
    set_ack(which, ch, 1'b0);
    tick(1);
  endtask

  // One-cycle readout request; rd_* outputs are valid on return.
  task automatic rd(input int unsigned which, input int unsigned sel);
    if (which == 2) begin
      rd_sel_s = 6'(sel);
      rd_req_s = 1'b1;
    end else begin
      rd_sel_m = 5'(sel);
      rd_req_m = 1'b1;
    end
    tick(1);
    rd_req_s = 1'b0;
    rd_req_m = 1'b0;
  endtask

  initial begin
    hs_m.pndng = '0; hs_m.pop = '0; hs_m.pndng_i_in = '0; hs_m.popin = '0;
    hs_s.pndng = '0; hs_s.pop = '0; hs_s.pndng_i_in = '0; hs_s.popin = '0;

    // Reset state
    tick(2);
    check("rst_ff", ff_m, 0);
    check("rst_any", any_m, 0);
    check("rst_vld", vld_m, 0);
    check("rst_pass", pass_m, 0);
    check("rst_fail", fail_m, 0);
    check("rst_late", late_m, 0);
    check("rst_lat", lat_m, 0);
    reset = 1'b0;
    en = 1'b1;
    tick(2);

    // Output-side pass, latency 10
    hs(0, 3, 10);
    rd(0, 3);
    check("p3_vld", vld_m, 1);
    check("p3_pass", pass_m, 1);
    check("p3_fail", fail_m, 0);
    check("p3_late", late_m, 0);
    check("p3_lat", lat_m, 10);
    check("p3_ff", ff_m[3], 0);
    tick(1);
    check("p3_vld_drop", vld_m, 0);

    // Input-side timeout on terminal 5 (channel 21), then late ack at t+60
    set_req(1, 5, 1'b1);
    tick(50);
    check("to_ff_before", ff_m[21], 0);
    tick(1);
    check("to_ff_after", ff_m[21], 1);
    check("to_any", any_m, 1);
    tick(9);
    set_ack(1, 5, 1'b1);
    tick(1);
    set_req(1, 5, 1'b0);
    set_ack(1, 5, 1'b0);
    tick(1);
    rd(0, 21);
    check("to_fail", fail_m, 1);
    check("to_late", late_m, 1);
    check("to_pass", pass_m, 0);

    // Window boundaries on channel 0
    hs(0, 0, 0);
    rd(0, 0);
    check("b0_pass", pass_m, 1);
    check("b0_lat", lat_m, 0);
    hs(0, 0, 50);
    rd(0, 0);
    check("b50_pass", pass_m, 2);
    check("b50_lat", lat_m, 50);
    check("b50_fail", fail_m, 0);
    check("b50_ff", ff_m[0], 0);
    hs(0, 0, 51);
    rd(0, 0);
    check("b51_pass", pass_m, 2);
    check("b51_fail", fail_m, 1);
    check("b51_late", late_m, 1);
    check("b51_ff", ff_m[0], 1);

    // clr on the same edge as a pop rise
    set_req(0, 3, 1'b1);
    tick(5);
    set_ack(0, 3, 1'b1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    set_req(0, 3, 1'b0);
    set_ack(0, 3, 1'b0);
    tick(1);
    rd(0, 3);
    check("clr_pass", pass_m, 0);
    check("clr_lat", lat_m, 0);
    check("clr_ff", ff_m, 0);
    check("clr_any", any_m, 0);
    rd(0, 21);
    check("clr_fail21", fail_m, 0);
    check("clr_late21", late_m, 0);

    // en low during WAIT abandons the attempt
    set_req(0, 1, 1'b1);
    tick(10);
    en = 1'b0;
    tick(60);
    en = 1'b1;
    tick(60);
    check("en_ff", ff_m[1], 0);
    check("en_any", any_m, 0);
    set_req(0, 1, 1'b0);
    tick(1);
    rd(0, 1);
    check("en_fail", fail_m, 0);
    check("en_pass", pass_m, 0);

    // Asynchronous reset mid-WAIT with outputs previously non-zero
    set_req(0, 2, 1'b1);
    tick(55);
    set_req(0, 2, 1'b0);
    hs(0, 0, 7);
    rd(0, 0);
    check("pre_pass", pass_m, 1);
    check("pre_lat", lat_m, 7);
    check("pre_any", any_m, 1);
    set_req(0, 4, 1'b1);
    tick(20);
    #2 reset = 1'b1;
    #1;
    check("ar_ff", ff_m, 0);
    check("ar_any", any_m, 0);
    check("ar_vld", vld_m, 0);
    check("ar_pass", pass_m, 0);
    check("ar_fail", fail_m, 0);
    check("ar_late", late_m, 0);
    check("ar_lat", lat_m, 0);
    set_req(0, 4, 1'b0);
    #1 reset = 1'b0;
    tick(100);
    check("ar_ff_100", ff_m, 0);
    check("ar_any_100", any_m, 0);
    rd(0, 4);
    check("ar_fail4", fail_m, 0);

    // Saturation on the narrow-counter instance, then out-of-range select
    for (int unsigned i = 0; i < 5; i++) hs(2, 7, 3);
    rd(2, 7);
    check("sat_vld", vld_s, 1);
    check("sat_pass", pass_s, 3);
    check("sat_fail", fail_s, 0);
    check("sat_lat", lat_s, 3);
    rd(2, 40);
    check("oor_vld", vld_s, 1);
    check("oor_pass", pass_s, 0);
    check("oor_fail", fail_s, 0);
    check("oor_late", late_s, 0);
    check("oor_lat", lat_s, 0);
    check("s_any", any_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
